// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: FSM state encoding and default frame geometry.
package tdm_demux_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEF_W   = 1;
    localparam int DEF_NCH = 2;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for the TDM receiver: clears, loads 1, or steps and wraps after NCH-1.
module tdm_slot_counter #(
    parameter int NCH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   load1,
    input  logic                   inc,
    output logic [$clog2(NCH)-1:0] slot,
    output logic                   last_slot
);

    localparam int CW = $clog2(NCH);

    assign last_slot = (slot == CW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= CW'(1);
        end else if (inc) begin
            slot <= last_slot ? '0 : slot + CW'(1);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: collects one word per slot into a shadow frame and presents complete frames in parallel.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int NCH = DEF_NCH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [NCH*W-1:0] dout,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    localparam int CW = $clog2(NCH);

    state_t              state_q, state_d;
    logic   [CW-1:0]     slot;
    logic                last_slot;
    logic                cnt_clr, cnt_load, cnt_inc;
    logic                sh_we;
    logic   [CW-1:0]     sh_idx;
    logic                fv_d, err_d;
    // Only slots 0..NCH-2 are buffered; the last slot's word goes straight into dout.
    logic   [(NCH-1)*W-1:0] shadow;

    tdm_slot_counter #(.NCH(NCH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .load1     (cnt_load),
        .inc       (cnt_inc),
        .slot      (slot),
        .last_slot (last_slot)
    );

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        sh_we    = 1'b0;
        sh_idx   = '0;
        fv_d     = 1'b0;
        err_d    = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        cnt_load = 1'b1;
                        sh_we    = 1'b1;
                        state_d  = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 restarts the frame on this beat.
                        cnt_load = 1'b1;
                        sh_we    = 1'b1;
                        err_d    = (slot != '0);
                    end else if (slot == '0) begin
                        cnt_clr  = 1'b1;
                        err_d    = 1'b1;
                        state_d  = HUNT;
                    end else if (last_slot) begin
                        cnt_inc  = 1'b1;
                        fv_d     = 1'b1;
                    end else begin
                        cnt_inc  = 1'b1;
                        sh_we    = 1'b1;
                        sh_idx   = slot;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            dout        <= '0;
            shadow      <= '0;
        end else begin
            state_q     <= state_d;
            frame_valid <= fv_d;
            sync_err    <= err_d;
            if (fv_d) begin
                dout <= {din, shadow};
            end
            for (int k = 0; k < NCH - 1; k++) begin
                if (sh_we && sh_idx == CW'(k)) begin
                    shadow[k*W +: W] <= din;
                end
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed vector table on a 2x1-bit instance, randomized traffic on a 5x3-bit instance.
module tb_tdm_demux;

    localparam int W2 = 1;
    localparam int N2 = 2;
    localparam int W5 = 3;
    localparam int N5 = 5;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic              s_rst, s_vld, s_din, s_sync;
    logic [N2*W2-1:0]  s_dout;
    logic              s_fv, s_lk, s_err;

    logic              b_rst, b_vld, b_sync;
    logic [W5-1:0]     b_din;
    logic [N5*W5-1:0]  b_dout;
    logic              b_fv, b_lk, b_err;

    tdm_demux #(.W(W2), .NCH(N2)) dut_small (
        .clk         (clk),
        .rst         (s_rst),
        .din         (s_din),
        .din_valid   (s_vld),
        .frame_sync  (s_sync),
        .dout        (s_dout),
        .frame_valid (s_fv),
        .locked      (s_lk),
        .sync_err    (s_err)
    );

    tdm_demux #(.W(W5), .NCH(N5)) dut_big (
        .clk         (clk),
        .rst         (b_rst),
        .din         (b_din),
        .din_valid   (b_vld),
        .frame_sync  (b_sync),
        .dout        (b_dout),
        .frame_valid (b_fv),
        .locked      (b_lk),
        .sync_err    (b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic       din;
        logic       sync;
        logic [1:0] dout;
        logic       fv;
        logic       lk;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic vld, input logic din, input logic sync,
                       input logic [1:0] d, input logic fv, input logic lk, input logic err);
        vec_t v;
        v.rst = rst; v.vld = vld; v.din = din; v.sync = sync;
        v.dout = d; v.fv = fv; v.lk = lk; v.err = err;
        tbl.push_back(v);
    endtask

    // Reference state for the randomized instance
    logic [W5-1:0]    frm[$];
    logic [N5*W5-1:0] m_dout;
    logic             m_fv, m_lk, m_err;
    int               pos;

    initial begin
        s_rst = 1'b1; s_vld = 1'b0; s_din = 1'b0; s_sync = 1'b0;
        b_rst = 1'b1; b_vld = 1'b0; b_din = '0;   b_sync = 1'b0;

        // rst, vld, din, sync | dout, fv, locked, err
        add(1,0,0,0, 2'b00,0,0,0);
        add(1,0,0,0, 2'b00,0,0,0);
        add(0,0,0,0, 2'b00,0,0,0);
        add(0,1,1,1, 2'b00,0,1,0);
        add(0,1,0,0, 2'b01,1,1,0);
        add(0,0,0,0, 2'b01,0,1,0);
        add(0,1,0,1, 2'b01,0,1,0);
        add(0,0,1,1, 2'b01,0,1,0);
        add(0,1,1,0, 2'b10,1,1,0);
        add(1,0,0,0, 2'b00,0,0,0);
        add(0,1,1,0, 2'b00,0,0,0);
        add(0,1,1,0, 2'b00,0,0,0);
        add(0,1,0,1, 2'b00,0,1,0);
        add(0,1,1,0, 2'b10,1,1,0);
        add(0,1,1,1, 2'b10,0,1,0);
        add(0,1,0,1, 2'b10,0,1,1);
        add(0,1,1,0, 2'b10,1,1,0);
        add(0,1,1,0, 2'b10,0,0,1);
        add(0,0,0,0, 2'b10,0,0,0);
        add(0,1,1,1, 2'b10,0,1,0);
        add(1,0,0,0, 2'b00,0,0,0);
        add(0,1,1,0, 2'b00,0,0,0);
        add(0,0,0,0, 2'b00,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            s_rst = tbl[i].rst; s_vld = tbl[i].vld; s_din = tbl[i].din; s_sync = tbl[i].sync;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dout", i),        64'(s_dout), 64'(tbl[i].dout));
            chk($sformatf("v%0d_frame_valid", i), 64'(s_fv),   64'(tbl[i].fv));
            chk($sformatf("v%0d_locked", i),      64'(s_lk),   64'(tbl[i].lk));
            chk($sformatf("v%0d_sync_err", i),    64'(s_err),  64'(tbl[i].err));
        end

        m_dout = '0; m_fv = 1'b0; m_lk = 1'b0; m_err = 1'b0; pos = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            b_rst  = (c == 0) || ($urandom_range(0, 399) == 0);
            b_vld  = ($urandom_range(0, 4) != 0);
            b_din  = W5'($urandom);
            b_sync = (pos == 0) ^ ($urandom_range(0, 11) == 0);

            m_fv  = 1'b0;
            m_err = 1'b0;
            if (b_rst) begin
                m_lk = 1'b0; m_dout = '0; frm.delete(); pos = 0;
            end else if (b_vld) begin
                pos = b_sync ? 1 : (pos + 1) % N5;
                if (!m_lk) begin
                    if (b_sync) begin
                        frm.delete(); frm.push_back(b_din); m_lk = 1'b1;
                    end
                end else if (b_sync) begin
                    m_err = (frm.size() != 0);
                    frm.delete(); frm.push_back(b_din);
                end else if (frm.size() == 0) begin
                    m_err = 1'b1; m_lk = 1'b0;
                end else begin
                    frm.push_back(b_din);
                    if (frm.size() == N5) begin
                        for (int k = 0; k < N5; k++) m_dout[k*W5 +: W5] = frm[k];
                        m_fv = 1'b1;
                        frm.delete();
                    end
                end
            end

            @(posedge clk);
            #1;
            chk($sformatf("r%0d_dout", c),        64'(b_dout), 64'(m_dout));
            chk($sformatf("r%0d_frame_valid", c), 64'(b_fv),   64'(m_fv));
            chk($sformatf("r%0d_locked", c),      64'(b_lk),   64'(m_lk));
            chk($sformatf("r%0d_sync_err", c),    64'(b_err),  64'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
